// File: rtl/ola_output_buffer.sv
// ---------------------------------------------------------------------------
// ola_output_buffer
//
// Transmit-side overlap-add buffer of the M/2 synthesis chain. It takes
// frames of fft_size complex samples from the synthesis PFB/IFFT. The first
// half of each frame is added, with saturation, to the second half of the
// previous frame, which is held in an overlap RAM. The result leaves as a
// continuous AXI-Stream of fft_size/2 samples per frame.
//
// Ports
//   clk            single clock
//   sync_reset     synchronous active-high reset
//   s_axis_tvalid  input sample valid
//   s_axis_tdata   input sample, I in [31:16], Q in [15:0], signed
//   s_axis_tlast   marks the last sample of an input frame
//   s_axis_tready  input accept
//   fft_size       frame length M, power of two 8..2048, static outside reset
//   m_axis_tvalid  output valid
//   m_axis_tdata   overlap-added sample
//   m_axis_tlast   last sample of each M/2 output block
//   m_axis_tready  output accept
//   frame_err      one-cycle pulse on a framing error
// ---------------------------------------------------------------------------
module ola_output_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int FFT_SIZE_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  input  logic                      s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
  output logic                      m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      frame_err
);

  localparam int HalfW     = DATA_WIDTH / 2;
  localparam int MemDepth  = 1024;
  localparam int AddrW     = 10;
  localparam int FifoDepth = 4;

  // Saturating add of two signed half-words. The two top bits of the
  // one-bit-wider sum disagree exactly when the result does not fit.
  function automatic logic [HalfW-1:0] satAdd(input logic [HalfW-1:0] a,
                                              input logic [HalfW-1:0] b);
    logic [HalfW:0] sum;
    sum = {a[HalfW-1], a} + {b[HalfW-1], b};
    case (sum[HalfW:HalfW-1])
      2'b01:   return {1'b0, {(HalfW-1){1'b1}}};
      2'b10:   return {1'b1, {(HalfW-1){1'b0}}};
      default: return sum[HalfW-1:0];
    endcase
  endfunction

  logic [FFT_SIZE_WIDTH-1:0] sampleIdx_q, sampleIdx_d;
  logic                      firstFrame_q, firstFrame_d;
  logic                      frameErr_q, frameErr_d;

  logic [FFT_SIZE_WIDTH-1:0] halfSize;
  logic [FFT_SIZE_WIDTH-1:0] lastIdx;
  logic                      firstHalf;
  logic [AddrW-1:0]          memAddr;
  logic                      accept;
  logic                      readyRaw;
  logic [2:0]                occupancy;

  logic [DATA_WIDTH-1:0]     olaMem [MemDepth];
  logic [DATA_WIDTH-1:0]     rdData_q;

  logic                      s1Valid_q;
  logic [DATA_WIDTH-1:0]     s1X_q;
  logic                      s1Zero_q;
  logic                      s1Last_q;

  logic [DATA_WIDTH-1:0]     memTerm;
  logic [DATA_WIDTH-1:0]     sumWord;
  logic                      s2Valid_q;
  logic [DATA_WIDTH-1:0]     s2Data_q;
  logic                      s2Last_q;

  logic [DATA_WIDTH-1:0]     fifoData_q [FifoDepth];
  logic                      fifoLast_q [FifoDepth];
  logic [1:0]                wrPtr_q;
  logic [1:0]                rdPtr_q;
  logic [2:0]                fifoCount_q;
  logic                      fifoPush;
  logic                      fifoPop;
  logic                      headValid;

  assign halfSize  = fft_size >> 1;
  assign lastIdx   = fft_size - FFT_SIZE_WIDTH'(1);
  assign firstHalf = sampleIdx_q < halfSize;

  // Both halves of a frame map onto the same M/2 overlap slots.
  assign memAddr = AddrW'(firstHalf ? sampleIdx_q : sampleIdx_q - halfSize);

  // Every first-half sample already in the pipeline is guaranteed a FIFO
  // slot, so first-half input is only taken while that total stays below
  // the FIFO depth. Second-half samples only write the RAM and are always
  // taken. Built from registered state only, so m_axis_tready never reaches
  // s_axis_tready combinationally.
  assign occupancy = fifoCount_q + 3'(s1Valid_q) + 3'(s2Valid_q);
  assign readyRaw  = firstHalf ? (occupancy < 3'(FifoDepth)) : 1'b1;

  assign s_axis_tready = !sync_reset && readyRaw;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Sample index and framing. A premature tlast realigns to a fresh frame
  // with no usable history; a missing tlast at the frame end is reported
  // but the index wraps normally and the history is kept.
  always_comb begin
    sampleIdx_d  = sampleIdx_q;
    firstFrame_d = firstFrame_q;
    frameErr_d   = 1'b0;
    if (accept) begin
      if (s_axis_tlast && (sampleIdx_q != lastIdx)) begin
        frameErr_d   = 1'b1;
        sampleIdx_d  = '0;
        firstFrame_d = 1'b1;
      end else if (sampleIdx_q == lastIdx) begin
        frameErr_d   = !s_axis_tlast;
        sampleIdx_d  = '0;
        firstFrame_d = 1'b0;
      end else begin
        sampleIdx_d  = sampleIdx_q + FFT_SIZE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sampleIdx_q  <= '0;
      firstFrame_q <= 1'b1;
      frameErr_q   <= 1'b0;
    end else begin
      sampleIdx_q  <= sampleIdx_d;
      firstFrame_q <= firstFrame_d;
      frameErr_q   <= frameErr_d;
    end
  end

  // Overlap RAM. Within one frame all reads come before all writes, and a
  // read and a write to the same slot are never in the same cycle, so the
  // registered read always returns the previous frame's data. The contents
  // are deliberately not cleared by reset; first_frame masks stale data.
  always_ff @(posedge clk) begin
    if (accept && !firstHalf) begin
      olaMem[memAddr] <= s_axis_tdata;
    end
    if (accept && firstHalf) begin
      rdData_q <= olaMem[memAddr];
    end
  end

  // Stage 1 carries the sample alongside its RAM read.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      s1Valid_q <= 1'b0;
    end else begin
      s1Valid_q <= accept && firstHalf;
    end
    s1X_q    <= s_axis_tdata;
    s1Zero_q <= firstFrame_q;
    s1Last_q <= sampleIdx_q == (halfSize - FFT_SIZE_WIDTH'(1));
  end

  // Stage 2 registers the saturated sum; I and Q clip independently.
  always_comb begin
    memTerm = s1Zero_q ? '0 : rdData_q;
    sumWord = {satAdd(s1X_q[DATA_WIDTH-1:HalfW], memTerm[DATA_WIDTH-1:HalfW]),
               satAdd(s1X_q[HalfW-1:0], memTerm[HalfW-1:0])};
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      s2Valid_q <= 1'b0;
    end else begin
      s2Valid_q <= s1Valid_q;
    end
    s2Data_q <= sumWord;
    s2Last_q <= s1Last_q;
  end

  // Output FIFO. Pushes are never refused: the input throttle above keeps
  // the number of live entries within the depth.
  assign headValid = fifoCount_q != 3'd0;
  assign fifoPush  = s2Valid_q;
  assign fifoPop   = headValid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      if (fifoPush) begin
        fifoData_q[wrPtr_q] <= s2Data_q;
        fifoLast_q[wrPtr_q] <= s2Last_q;
        wrPtr_q             <= wrPtr_q + 2'd1;
      end
      if (fifoPop) begin
        rdPtr_q <= rdPtr_q + 2'd1;
      end
      fifoCount_q <= fifoCount_q + 3'(fifoPush) - 3'(fifoPop);
    end
  end

  // Outputs are forced to their idle values for as long as reset is held,
  // which also drops a stalled output word at once.
  assign m_axis_tvalid = !sync_reset && headValid;
  assign m_axis_tdata  = m_axis_tvalid ? fifoData_q[rdPtr_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid && fifoLast_q[rdPtr_q];
  assign frame_err     = !sync_reset && frameErr_q;

endmodule

// File: doc/ola_output_buffer.md
# ola_output_buffer

M/2 synthesis overlap-add output buffer: the transmit-side counterpart of the channelizer's input buffer. It sits after the synthesis PFB/IFFT in the M/2 synthesizer chain and consumes frames of `fft_size` complex samples. For each frame it adds the first half to the stored second half of the previous frame, and emits `fft_size/2` samples per frame as a continuous AXI-Stream.

## Interface
Parameters:
- `DATA_WIDTH`, 32: sample width; I in [31:16], Q in [15:0], both signed 16-bit.
- `FFT_SIZE_WIDTH`, 12: width of `fft_size`.

Ports:
- `clk` in 1: single clock.
- `sync_reset` in 1: reset, synchronous, active-high.
- `s_axis_tvalid` in 1: input sample valid.
- `s_axis_tdata` in 32: input sample.
- `s_axis_tlast` in 1: last sample of an input frame.
- `s_axis_tready` out 1: input accept.
- `fft_size` in 12: frame length M; power of two, 8..2048. Static outside reset; the top level pulses `sync_reset` on every change.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tdata` out 32: overlap-added sample.
- `m_axis_tlast` out 1: last sample of each M/2 output block.
- `m_axis_tready` in 1: output accept.
- `frame_err` out 1: one-cycle pulse on a framing error.

## Operation
- Sample index `k` counts accepted inputs 0..M-1 and wraps to 0.
- Overlap memory: 1024 x 32 simple dual-port RAM, 1-cycle read latency, addressed by `k mod M/2`.
- First half, k < M/2:
  - read `ola_mem[k]`;
  - output sat(x[k] + ola_mem[k]) per component;
  - if `first_frame` = 1, the memory term is forced to 0.
- Second half, k >= M/2:
  - write x[k] to `ola_mem[k - M/2]`;
  - produce no output.
- Reads and writes of one frame are ordered (all reads precede all writes), so reads always return the previous frame's data. No bypass is required.
- `first_frame` is set by reset and by error realignment. It clears when k = M-1 is accepted.
- Arithmetic:
  - 17-bit signed sum per component;
  - clip to 16 bits: > 32767 -> 0x7FFF, < -32768 -> 0x8000;
  - I and Q saturate independently.
- `m_axis_tlast` = 1 on the output produced from k = M/2-1.
- Framing:
  - `s_axis_tlast` at k != M-1: pulse `frame_err`, next k = 0, set `first_frame`. The partial frame's outputs already issued remain valid.
  - k = M-1 without `s_axis_tlast`: pulse `frame_err`, wrap normally, keep history.
- Output stage: 4-entry FIFO after the add register; `m_axis_*` is driven from the FIFO head.
- `s_axis_tready`:
  - in the second half: 1;
  - in the first half: 1 only when FIFO occupancy + in-flight pipeline entries < 4.
  - This guarantees the FIFO never overflows.

## Timing
- Reset values, held while `sync_reset` = 1:
  - `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, `frame_err` = 0; `m_axis_tdata` = 0;
  - k = 0, `first_frame` = 1, FIFO empty.
- `s_axis_tready` may assert on the first cycle after reset deasserts.
- Latency: a first-half sample accepted at cycle n appears on `m_axis_tvalid` at cycle n+3 when the FIFO is empty and `m_axis_tready` = 1. The three stages are RAM read, add/saturate register, FIFO head.
- Throughput: 1 input per cycle sustained, with `m_axis_tready` held high. Output duty is 50% of input rate.
- AXI rules:
  - `m_axis_tdata`/`m_axis_tlast` are stable while tvalid=1 and tready=0;
  - `m_axis_tvalid` never drops without a handshake;
  - no combinational path from `m_axis_tready` to `s_axis_tready`: ready derives from registered occupancy.
- Reset mid-frame or mid-stall: pipeline and FIFO are flushed; the held output is dropped; history is invalidated via `first_frame`. RAM contents are not cleared.
- `frame_err` asserts the cycle after the offending input is accepted.

## Test plan
- M=8, I = 1..8 (Q=0) then I = 10..17 -> outputs I = 1,2,3,4 (tlast on 4), then 15,17,19,21 (tlast on 21), with `frame_err` never asserted.
- Saturation, M=8: second half of frame 1 = (30000,-30000); frame 2 first half = (10000,-10000) -> outputs 0x7FFF/0x8000 on all 4 samples.
- Random `m_axis_tready` (~30%) with a continuous 2048-point input of 20 frames -> output matches the reference model bit-exactly; no FIFO overflow; `s_axis_tready` drops only during first halves.
- M=16, `s_axis_tlast` at k=5 -> `frame_err` pulse; the next frame outputs its raw first half (no overlap term); the following frame overlaps correctly.
- Reset asserted at k=3 with the output stalled -> all outputs 0 during reset; after release the first frame outputs raw x[k].
- M=2048, 3 frames -> 1024 outputs per frame; `m_axis_tlast` on every 1024th output.
